spi_cmd_rx: RTL and testbench
=============================

# spi_cmd_rx

Front-end byte receiver for the control path: a mode-0 SPI slave running off the system clock. It deserialises MOSI bytes into a first-word-fall-through FIFO and presents them to the control unit as `out_byte`/`out_ready`. It pops one byte per `next` pulse. It also serialises the control unit's echo byte back out on MISO.

## Interface
Parameters:
- `fifo_depth`, 16, FIFO entries; must be a power of two, ≥2
- `sync_stages`, 2, synchroniser flops on `sck`, `mosi` and `cs_n`

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `sck`  in  1  SPI clock, asynchronous to `clk`
- `mosi`  in  1  SPI data in, MSB first
- `cs_n`  in  1  SPI chip select, active low
- `miso`  out  1  SPI data out
- `out_byte`  out  8  FIFO head byte; valid while `out_ready`=1
- `out_ready`  out  1  FIFO non-empty
- `next`  in  1  single-cycle pop strobe from the control unit
- `tx_byte`  in  8  byte to shift out on MISO (the control unit's `spi_output`)
- `fifo_count`  out  $clog2(fifo_depth)+1  current occupancy
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full
- `clear_overflow`  in  1  single-cycle strobe that clears `overflow`

## Operation
- `sck`, `mosi` and `cs_n` each pass through `sync_stages` flops. Edge detection runs on the synchronised `sck`. `sck` must be ≤ `clk`/8.
- Frame states: IDLE (`cs_n`=1) and ACTIVE (`cs_n`=0).
- IDLE→ACTIVE on synchronised `cs_n` falling:
  - bit counter ← 0
  - RX shift register ← 0
  - TX shift register ← `tx_byte`
- ACTIVE, sck rising:
  - RX shift ← {shift[6:0], mosi_sync}
  - bit counter +1
  - at the 8th bit: push {shift[6:0], mosi_sync} to the FIFO and set bit counter ← 0
- ACTIVE, sck falling:
  - TX shift ← {shift[6:0], 0}
  - after the 8th falling edge of a byte, TX shift ← `tx_byte`
- `miso` = TX shift[7] while ACTIVE, 0 while IDLE.
- ACTIVE→IDLE on `cs_n` rising. A partial byte (bit counter ≠ 0) is discarded and never pushed.
- FIFO behaviour:
  - Circular buffer with read and write pointers one bit wider than the address.
  - full = (pointer MSBs differ, lower bits equal); empty = (pointers equal).
  - Pointers wrap naturally at `fifo_depth`.
- Push while full: byte dropped, pointers unchanged, `overflow` ← 1.
- `next` while empty: ignored, no underflow.
- Push and pop in the same cycle with the FIFO non-empty: both take effect and `fifo_count` is unchanged.
  - Push and pop with the FIFO full: the pop frees a slot and the push is accepted.
  - Push and pop with the FIFO empty: the pop is ignored and the push is accepted.
- `overflow` set and `clear_overflow` in the same cycle: set wins.

## Timing
- Reset values:
  - `out_byte` = 0x00, `out_ready` = 0, `fifo_count` = 0, `overflow` = 0, `miso` = 0
  - FSM in IDLE; pointers, shift registers and synchronisers all 0
  - synchroniser flops on `cs_n` reset to 1
- `out_byte` and `out_ready` are registered and reflect FIFO state after the previous edge.
- Push latency: 8th `sck` rising at the pin → push at `clk` edge `sync_stages`+1 → `out_ready`=1 one edge later (4 cycles at defaults).
- Pop: `next` sampled high at edge N → at edge N+1, `out_byte` shows the new head, or `out_ready`=0 if the FIFO is now empty. This matches the control unit's one-cycle `wait_one` gap.
- `tx_byte` is sampled only at frame start and at byte boundaries. Changes at other times have no effect on the byte in flight.
- Reset asserted mid-frame: everything returns to reset values immediately; FIFO contents are lost.

## Configuration
- `SPI_RX_MISO_ECHO_EN`:
  - Defined: the TX shift register, `tx_byte` loading and `miso` drive operate as described above.
  - Undefined: the TX logic is not built, `miso` is tied to 0 and `tx_byte` is unused. The RX path and FIFO are unchanged.

## Test plan
- After reset, send one frame containing 0xA5 → `out_ready` rises 4 cycles after the 8th sck edge, `out_byte`=0xA5, `fifo_count`=1. Pulse `next` → `out_ready`=0 on the next cycle.
- Send 3 bytes 0x01 0x02 0x03 in one frame, then pop with `next` every other cycle → outputs appear in order 01, 02, 03, then empty; `fifo_count` steps 3→2→1→0.
- Send 17 bytes with `fifo_depth`=16 and no pops → `fifo_count`=16, `overflow`=1, head=first byte, 17th byte lost. Pulse `clear_overflow` → `overflow`=0.
- Raise `cs_n` after 5 bits of 0xFF, then send a full frame with 0x3C → only 0x3C is queued, `fifo_count`=1.
- With the FIFO full, push and pop in the same cycle → `fifo_count` stays 16, no overflow, new byte lands at the tail. Separately, pulse `next` while empty → nothing changes.
- With `SPI_RX_MISO_ECHO_EN` defined and `tx_byte`=0xC3 at `cs_n` fall → MISO sampled by the master on rising edges reads 0xC3 MSB first. With the macro undefined → MISO reads 0x00.

Source files
------------

// File: rtl/spi_cmd_rx.sv
// Mode-0 SPI slave byte receiver feeding a first-word-fall-through FIFO for the control unit.
// Define SPI_RX_MISO_ECHO_EN to build the MISO echo path; otherwise miso is tied low.
module spi_cmd_rx #(
  parameter int unsigned fifo_depth  = 16,
  parameter int unsigned sync_stages = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          mosi,
  input  logic                          cs_n,
  output logic                          miso,
  output logic [7:0]                    out_byte,
  output logic                          out_ready,
  input  logic                          next,
  input  logic [7:0]                    tx_byte,
  output logic [$clog2(fifo_depth):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned AW = $clog2(fifo_depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SS = sync_stages;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic [SS-1:0] r_sck_s;
  logic [SS-1:0] r_mosi_s;
  logic [SS-1:0] r_cs_s;
  logic          r_sck_d;
  logic          w_sck;
  logic          w_mosi;
  logic          w_cs;
  logic          w_rise;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_rx_shift;
  logic          w_push;
  logic [7:0]    w_push_byte;

  logic [7:0]    r_mem [fifo_depth];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_drop;
  logic [7:0]    r_out_byte;
  logic          r_out_ready;
  logic [PW-1:0] r_count;
  logic          r_overflow;

  // Input synchronisers; cs_n idles high so its chain resets to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_s  <= '0;
      r_mosi_s <= '0;
      r_cs_s   <= '1;
      r_sck_d  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[SS-2:0], sck};
      r_mosi_s <= {r_mosi_s[SS-2:0], mosi};
      r_cs_s   <= {r_cs_s[SS-2:0], cs_n};
      r_sck_d  <= r_sck_s[SS-1];
    end
  end

  assign w_sck  = r_sck_s[SS-1];
  assign w_mosi = r_mosi_s[SS-1];
  assign w_cs   = r_cs_s[SS-1];
  assign w_rise = w_sck & ~r_sck_d;

  // Frame FSM and RX deserialiser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_cs) begin
            r_state    <= S_ACTIVE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
          end
        end
        S_ACTIVE: begin
          if (w_cs) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
          end else if (w_rise) begin
            r_rx_shift <= {r_rx_shift[6:0], w_mosi};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A byte completes on the 8th rising edge; a deselect in the same cycle wins
  assign w_push      = (r_state == S_ACTIVE) & ~w_cs & w_rise & (r_bit_cnt == 3'd7);
  assign w_push_byte = {r_rx_shift[6:0], w_mosi};

`ifdef SPI_RX_MISO_ECHO_EN
  logic       w_fall;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_cnt;
  logic       r_miso;

  assign w_fall = ~w_sck & r_sck_d;

  // TX serialiser: tx_byte is sampled only at frame start and byte boundaries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_shift <= 8'h00;
      r_tx_cnt   <= 3'd0;
      r_miso     <= 1'b0;
    end else begin
      r_miso <= (r_state == S_ACTIVE) ? r_tx_shift[7] : 1'b0;
      if (r_state == S_IDLE) begin
        if (!w_cs) begin
          r_tx_shift <= tx_byte;
          r_tx_cnt   <= 3'd0;
        end
      end else if (!w_cs && w_fall) begin
        if (r_tx_cnt == 3'd7) begin
          r_tx_shift <= tx_byte;
          r_tx_cnt   <= 3'd0;
        end else begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          r_tx_cnt   <= r_tx_cnt + 3'd1;
        end
      end
    end
  end

  assign miso = r_miso;
`else
  logic w_unused_tx;
  assign w_unused_tx = ^tx_byte;
  assign miso        = 1'b0;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = next & ~w_empty;
  assign w_wr_en = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // FIFO storage carries no reset; its contents are meaningless until written
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_push_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_byte  <= 8'h00;
      r_out_ready <= 1'b0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_out_ready <= ~w_empty;
      r_out_byte  <= w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
      r_count     <= r_wr_ptr - r_rd_ptr;
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign out_byte   = r_out_byte;
  assign out_ready  = r_out_ready;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: table of single-byte frames plus hand sequences for
// latency, ordering, overflow, full-FIFO push/pop collision, empty pop and mid-frame reset.
module tb_spi_cmd_rx;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          HALF  = 6;
`ifdef SPI_RX_MISO_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          sck;
  logic          mosi;
  logic          cs_n;
  logic          miso;
  logic [7:0]    out_byte;
  logic          out_ready;
  logic          next;
  logic [7:0]    tx_byte;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  spi_cmd_rx #(.fifo_depth(DEPTH), .sync_stages(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .sck            (sck),
    .mosi           (mosi),
    .cs_n           (cs_n),
    .miso           (miso),
    .out_byte       (out_byte),
    .out_ready      (out_ready),
    .next           (next),
    .tx_byte        (tx_byte),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] data;
    int         nbits;
    int         exp_count;
    logic       exp_ready;
    logic [7:0] exp_head;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clks(HALF);
    sck = 1'b1;
    m = miso;
    wait_clks(HALF);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] m);
    logic bit_rd;
    logic [7:0] data;
    data = b;
    m = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(data[7-i], bit_rd);
      m = {m[6:0], bit_rd};
    end
  endtask

  task automatic cs_start(input logic [7:0] tx);
    tx_byte = tx;
    cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic cs_end();
    wait_clks(8);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic pop();
    next = 1'b1;
    wait_clks(1);
    next = 1'b0;
    wait_clks(1);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] exp_m;

    vecs[0] = '{8'hC3, 8'hA5, 8, 1, 1'b1, 8'hA5, 8'hC3};
    vecs[1] = '{8'h00, 8'hFF, 5, 0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{8'h5A, 8'h3C, 8, 1, 1'b1, 8'h3C, 8'h5A};
    vecs[3] = '{8'hFF, 8'h00, 8, 1, 1'b1, 8'h00, 8'hFF};
    vecs[4] = '{8'h81, 8'h80, 3, 0, 1'b0, 8'h00, 8'h04};
    vecs[5] = '{8'h7E, 8'h01, 8, 1, 1'b1, 8'h01, 8'h7E};

    reset = 1'b0; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    next = 1'b0; tx_byte = 8'h00; clear_overflow = 1'b0;
    wait_clks(3);
    check("reset out_byte", 32'(out_byte), 32'h00);
    check("reset out_ready", 32'(out_ready), 32'h0);
    check("reset fifo_count", 32'(fifo_count), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset miso", 32'(miso), 32'h0);
    reset = 1'b1;
    wait_clks(4);

    // Push latency of one byte, measured from the 8th sck rising edge
    cs_start(8'h00);
    spi_byte(8'hA5, 7, m);
    mosi = 1'b1;
    wait_clks(HALF);
    sck = 1'b1;
    wait_clks(3);
    check("latency ready@3", 32'(out_ready), 32'h0);
    wait_clks(1);
    check("latency ready@4", 32'(out_ready), 32'h1);
    check("latency byte", 32'(out_byte), 32'hA5);
    check("latency count", 32'(fifo_count), 32'h1);
    wait_clks(HALF);
    sck = 1'b0;
    cs_end();
    pop();
    check("pop ready", 32'(out_ready), 32'h0);
    check("pop count", 32'(fifo_count), 32'h0);

    // Table of single-byte frames, including partial bytes
    foreach (vecs[i]) begin
      cs_start(vecs[i].tx);
      spi_byte(vecs[i].data, vecs[i].nbits, m);
      cs_end();
      exp_m = ECHO ? vecs[i].exp_miso : 8'h00;
      check($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d ready", i), 32'(out_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d miso", i), 32'(m), 32'(exp_m));
      check($sformatf("vec%0d idle miso", i), 32'(miso), 32'h0);
      if (vecs[i].exp_ready) begin
        check($sformatf("vec%0d head", i), 32'(out_byte), 32'(vecs[i].exp_head));
        pop();
        check($sformatf("vec%0d drained", i), 32'(out_ready), 32'h0);
      end
    end

    // Three bytes in one frame come out in order
    cs_start(8'h00);
    for (int i = 1; i <= 3; i++) spi_byte(8'(i), 8, m);
    cs_end();
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("order%0d count", i), 32'(fifo_count), 32'(4 - i));
      check($sformatf("order%0d head", i), 32'(out_byte), 32'(i));
      pop();
    end
    check("order empty ready", 32'(out_ready), 32'h0);
    check("order empty count", 32'(fifo_count), 32'h0);

    // 17 bytes into a 16-deep FIFO: last one dropped, sticky overflow
    cs_start(8'h00);
    for (int i = 0; i < 17; i++) spi_byte(8'(8'h10 + i), 8, m);
    cs_end();
    check("ovf count", 32'(fifo_count), 32'd16);
    check("ovf flag", 32'(overflow), 32'h1);
    check("ovf head", 32'(out_byte), 32'h10);
    clear_overflow = 1'b1;
    wait_clks(1);
    clear_overflow = 1'b0;
    wait_clks(1);
    check("ovf cleared", 32'(overflow), 32'h0);

    // Full FIFO: pop coincident with the push cycle
    cs_start(8'h00);
    spi_byte(8'h55, 7, m);
    mosi = 1'b1;
    wait_clks(HALF);
    sck = 1'b1;
    wait_clks(2);
    next = 1'b1;
    wait_clks(1);
    next = 1'b0;
    wait_clks(HALF);
    sck = 1'b0;
    cs_end();
    check("collide count", 32'(fifo_count), 32'd16);
    check("collide ovf", 32'(overflow), 32'h0);
    check("collide head", 32'(out_byte), 32'h11);
    for (int i = 0; i < 16; i++) begin
      exp_m = (i < 15) ? 8'(8'h11 + i) : 8'h55;
      check($sformatf("drain%0d", i), 32'(out_byte), 32'(exp_m));
      pop();
    end
    check("drain empty", 32'(out_ready), 32'h0);

    // Pop while empty is ignored
    pop();
    pop();
    check("empty pop count", 32'(fifo_count), 32'h0);
    check("empty pop ready", 32'(out_ready), 32'h0);
    cs_start(8'h00);
    spi_byte(8'h6B, 8, m);
    cs_end();
    check("after empty pop count", 32'(fifo_count), 32'h1);
    check("after empty pop head", 32'(out_byte), 32'h6B);

    // Reset mid-frame clears everything
    cs_start(8'hFF);
    spi_byte(8'hF0, 5, m);
    reset = 1'b0;
    wait_clks(1);
    check("midreset count", 32'(fifo_count), 32'h0);
    check("midreset ready", 32'(out_ready), 32'h0);
    check("midreset miso", 32'(miso), 32'h0);
    sck = 1'b0;
    cs_n = 1'b1;
    wait_clks(2);
    reset = 1'b1;
    wait_clks(10);
    check("post reset ready", 32'(out_ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
